queue_ctrl: RTL and testbench
=============================

# queue_ctrl

8-entry, 4-bit circular FIFO controller that owns the queue register file, its valid bits and the head pointer. It sequences enqueue/dequeue requests from the push-button front end through a small FSM. It shares the register file's single read port between dequeue and the segment-display scanner, which reads via `ra_disp` and `rd_disp`. It sits between the input debouncers and the display scanner in the FIFO top level.

## Interface
Parameters:
- none (depth fixed at 8, width fixed at 4)

Ports:
- `clk` input 1: system clock; all state changes on rising edge
- `rstn` input 1: reset, asynchronous, active-low
- `enq` input 1: enqueue request level, already debounced and synchronized; a rising edge requests one enqueue
- `deq` input 1: dequeue request level, already debounced and synchronized; a rising edge requests one dequeue
- `in` input 4: data to enqueue, sampled when the write occurs
- `ra_disp` input 3: display scanner read address (absolute index 0..7)
- `rd_disp` output 4: registered read data for `ra_disp`
- `disp_stall` output 1: 1 while dequeue owns the read port; `rd_disp` holds during this
- `out` output 4: last dequeued value
- `valid` output 8: per-entry valid bits, indexed by absolute slot
- `p` output 3: head pointer (oldest entry)
- `full` output 1: count == 8
- `empty` output 1: count == 0

## Operation
- Storage and pointers:
  - `rf[0:7]` is 4 bits per slot.
  - Head `p` and tail `t` are 3 bits each and wrap 7→0 modulo 8.
  - `count` is 4 bits, range 0..8.
- Edge detect:
  - `enq_r` and `deq_r` are the previous-cycle samples of `enq` and `deq`.
  - A cycle with `enq & ~enq_r` sets `enq_pend`; `deq & ~deq_r` sets `deq_pend`.
  - Edges are latched in any FSM state. A second edge while pending is already set is absorbed.
- FSM states: IDLE, ENQ, DEQ.
  - IDLE, `enq_pend`=1:
    - If `full`: clear `enq_pend`, no write, stay IDLE.
    - Otherwise: go to ENQ.
  - IDLE, `enq_pend`=0 and `deq_pend`=1:
    - If `empty`: clear `deq_pend`, stay IDLE.
    - Otherwise: go to DEQ.
  - Enqueue has priority over dequeue when both are pending.
  - ENQ (one cycle), at its closing edge:
    - `rf[t]`←`in`, `valid[t]`←1, `t`←`t`+1, `count`+1, clear `enq_pend`.
    - Next state IDLE.
  - DEQ (one cycle), read address = `p`, at its closing edge:
    - `out`←`rf[p]`, `valid[p]`←0, `p`←`p`+1, `count`−1, clear `deq_pend`.
    - Next state IDLE.
  - A new edge arriving in the same cycle its pending flag is being cleared leaves the flag set (set wins).
- Read-port arbitration:
  - In DEQ: the port reads `rf[p]`, `disp_stall`=1, `rd_disp` holds its value.
  - Otherwise: `rd_disp`←`rf[ra_disp]` every cycle.
  - The display sees the new tail value one cycle after the ENQ write.
- `full` and `empty` are combinational from `count`.
- Reset mid-operation aborts any ENQ or DEQ without a partial write and drops all pending requests.

## Timing
- Reset values:
  - `out`=0, `rd_disp`=0, `valid`=0, `p`=0, `t`=0, `count`=0.
  - `full`=0, `empty`=1, `disp_stall`=0.
  - `enq_r`=`deq_r`=0, pendings 0, state IDLE, all `rf` slots 0.
- Enqueue latency (edge detected at posedge k):
  - Pending set at k; state ENQ after k+1.
  - Write, `valid`, and `count` visible after k+2.
- Dequeue latency: `out`, `valid`, and `p` update after posedge k+2.
- Simultaneous enq and deq edges: ENQ completes at k+2, DEQ completes at k+4 (IDLE at k+3 in between).
  - On an empty queue this returns the just-enqueued value.
- Throughput: one operation per 2 cycles.
- `disp_stall` is high for exactly the one DEQ cycle.

## Test plan
- Reset with `rstn`=0 → every output at its reset value; release, idle 10 cycles → no change.
- Enqueue 3, 5, 9 (one `enq` pulse each, `in` set before each pulse) → `valid`=8'b0000_0111, `p`=0, `rd_disp` for `ra_disp`=1 is 5; one `deq` pulse → `out`=3, `p`=1, `valid`=8'b0000_0110.
- Enqueue 9 times from empty → `full`=1 after the 8th; 9th request dropped, `valid`=8'hFF, `count`=8.
- Wrap-around: 8 enqueues, 8 dequeues, then enqueue 7 → value lands in slot 0, `p`=0, `valid`=8'h01; dequeue on empty → ignored, `out` unchanged.
- Empty queue, `enq` and `deq` rise in the same cycle with `in`=4 → after 4 cycles `out`=4, `empty`=1; `disp_stall` high exactly 1 cycle with `rd_disp` held.
- `rstn` pulsed low during the ENQ cycle → no write, `valid`=0, all pendings cleared.

Source files
------------

// File: rtl/queue_ctrl.sv
// queue_ctrl: 8-entry x 4-bit circular FIFO controller. Owns the register
// file, per-slot valid bits and head/tail pointers, sequences push-button
// enqueue/dequeue requests through a three-state FSM, and shares the single
// register-file read port between dequeue and the display scanner.
module queue_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enq,
  input  logic       deq,
  input  logic [3:0] in,
  input  logic [2:0] ra_disp,
  output logic [3:0] rd_disp,
  output logic       disp_stall,
  output logic [3:0] out,
  output logic [7:0] valid,
  output logic [2:0] p,
  output logic       full,
  output logic       empty
);

  typedef enum logic [1:0] {IDLE, ENQ, DEQ} state_t;

  state_t      state_q, state_d;
  logic        enq_r_q, deq_r_q;
  logic        enq_pend_q, enq_pend_d;
  logic        deq_pend_q, deq_pend_d;
  logic [2:0]  p_q, p_d;
  logic [2:0]  t_q, t_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  valid_q, valid_d;
  logic [3:0]  out_q, out_d;
  logic [3:0]  rd_disp_q, rd_disp_d;
  logic [3:0]  rf_q [8];
  logic [3:0]  rf_d [8];
  logic        enq_edge, deq_edge;
  logic        enq_clr, deq_clr;

  // Rising-edge detection against the previous-cycle samples
  assign enq_edge = enq & ~enq_r_q;
  assign deq_edge = deq & ~deq_r_q;

  assign full       = (count_q == 4'd8);
  assign empty      = (count_q == 4'd0);
  assign disp_stall = (state_q == DEQ);
  assign rd_disp    = rd_disp_q;
  assign out        = out_q;
  assign valid      = valid_q;
  assign p          = p_q;

  // Next-state, queue update and read-port arbitration
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    t_d       = t_q;
    count_d   = count_q;
    valid_d   = valid_q;
    out_d     = out_q;
    rf_d      = rf_q;
    enq_clr   = 1'b0;
    deq_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        // Enqueue wins when both are pending; requests that cannot be
        // honoured (full/empty) are simply dropped.
        if (enq_pend_q) begin
          if (full) enq_clr = 1'b1;
          else      state_d = ENQ;
        end else if (deq_pend_q) begin
          if (empty) deq_clr = 1'b1;
          else       state_d = DEQ;
        end
      end
      ENQ: begin
        rf_d[t_q]    = in;
        valid_d[t_q] = 1'b1;
        t_d          = t_q + 3'd1;
        count_d      = count_q + 4'd1;
        enq_clr      = 1'b1;
        state_d      = IDLE;
      end
      DEQ: begin
        out_d        = rf_q[p_q];
        valid_d[p_q] = 1'b0;
        p_d          = p_q + 3'd1;
        count_d      = count_q - 4'd1;
        deq_clr      = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge in the same cycle as the clear keeps the request alive
    enq_pend_d = (enq_pend_q & ~enq_clr) | enq_edge;
    deq_pend_d = (deq_pend_q & ~deq_clr) | deq_edge;
    // Dequeue owns the read port during DEQ; the display value is frozen
    rd_disp_d  = (state_q == DEQ) ? rd_disp_q : rf_q[ra_disp];
  end

  // State, pointer and storage registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      enq_r_q    <= 1'b0;
      deq_r_q    <= 1'b0;
      enq_pend_q <= 1'b0;
      deq_pend_q <= 1'b0;
      p_q        <= 3'd0;
      t_q        <= 3'd0;
      count_q    <= 4'd0;
      valid_q    <= 8'd0;
      out_q      <= 4'd0;
      rd_disp_q  <= 4'd0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      enq_r_q    <= enq;
      deq_r_q    <= deq;
      enq_pend_q <= enq_pend_d;
      deq_pend_q <= deq_pend_d;
      p_q        <= p_d;
      t_q        <= t_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      rd_disp_q  <= rd_disp_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: directed and randomized checks of queue_ctrl against a
// transaction-level FIFO model (SV queue + slot image).
module tb_queue_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enq_s = 1'b0;
  logic       deq_s = 1'b0;
  logic [3:0] in_s = 4'd0;
  logic [2:0] ra_disp_s = 3'd0;
  logic [3:0] rd_disp_s;
  logic       disp_stall_s;
  logic [3:0] out_s;
  logic [7:0] valid_s;
  logic [2:0] p_s;
  logic       full_s;
  logic       empty_s;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, head slot, last dequeued value, slot image
  logic [3:0] mq[$];
  int         mhead = 0;
  logic [3:0] mout = 4'd0;
  logic [3:0] mrf [8];

  queue_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .enq       (enq_s),
    .deq       (deq_s),
    .in        (in_s),
    .ra_disp   (ra_disp_s),
    .rd_disp   (rd_disp_s),
    .disp_stall(disp_stall_s),
    .out       (out_s),
    .valid     (valid_s),
    .p         (p_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_valid();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < mq.size(); i++) v[(mhead + i) % 8] = 1'b1;
    return v;
  endfunction

  task automatic m_reset();
    mq.delete();
    mhead = 0;
    mout  = 4'd0;
    for (int i = 0; i < 8; i++) mrf[i] = 4'd0;
  endtask

  task automatic m_enq(input logic [3:0] v);
    if (mq.size() < 8) begin
      mrf[(mhead + mq.size()) % 8] = v;
      mq.push_back(v);
    end
  endtask

  task automatic m_deq();
    if (mq.size() > 0) begin
      mout  = mq.pop_front();
      mhead = (mhead + 1) % 8;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, valid_s, m_valid());
    chk({tag, ".p"},     p_s,     mhead);
    chk({tag, ".out"},   out_s,   mout);
    chk({tag, ".full"},  full_s,  (mq.size() == 8));
    chk({tag, ".empty"}, empty_s, (mq.size() == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; enq_s = 1'b0; deq_s = 1'b0;
    #3;
    chk("rst.rd_disp", rd_disp_s, 0);
    chk("rst.out", out_s, 0);
    chk("rst.valid", valid_s, 0);
    chk("rst.p", p_s, 0);
    chk("rst.full", full_s, 0);
    chk("rst.empty", empty_s, 1);
    chk("rst.stall", disp_stall_s, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
  endtask

  // One-cycle request pulse straddling exactly one rising edge
  task automatic pulse(input bit e, input bit d, input logic [3:0] v);
    @(negedge clk);
    in_s = v; enq_s = e; deq_s = d;
    @(negedge clk);
    enq_s = 1'b0; deq_s = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit e, input bit d, input logic [3:0] v);
    pulse(e, d, v);
    repeat (4) @(posedge clk);
    #1;
    if (e) m_enq(v);
    if (d) m_deq();
    check_all(tag);
  endtask

  task automatic chk_disp(input string tag, input logic [2:0] a);
    @(negedge clk);
    ra_disp_s = a;
    @(posedge clk);
    #1;
    chk(tag, rd_disp_s, mrf[a]);
  endtask

  initial begin
    int stalls, stall_at;
    logic [3:0] rd_during, rd_after, out_at4;
    m_reset();

    // Reset and quiet idle
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check_all("idle");
    chk("idle.rd_disp", rd_disp_s, 0);

    // Enqueue latency: nothing visible after k+1, write visible after k+2
    pulse(1'b1, 1'b0, 4'd3);
    @(posedge clk); #1;
    chk("lat.k1.valid", valid_s, 8'h00);
    @(posedge clk); #1;
    chk("lat.k2.valid", valid_s, 8'h01);
    chk("lat.k2.empty", empty_s, 0);
    m_enq(4'd3);
    repeat (2) @(posedge clk);
    do_op("e5", 1'b1, 1'b0, 4'd5);
    do_op("e9", 1'b1, 1'b0, 4'd9);
    chk("three.valid", valid_s, 8'b0000_0111);
    chk_disp("three.rd1", 3'd1);
    chk("three.rd1.const", rd_disp_s, 4'd5);
    do_op("d1", 1'b0, 1'b1, 4'd0);
    chk("d1.out", out_s, 4'd3);
    chk("d1.p", p_s, 3'd1);
    chk("d1.valid", valid_s, 8'b0000_0110);

    // Fill to full, ninth request dropped
    do_reset();
    for (int i = 0; i < 9; i++) do_op("fill", 1'b1, 1'b0, 4'(i + 1));
    chk("full.valid", valid_s, 8'hFF);
    chk("full.full", full_s, 1);
    for (int a = 0; a < 8; a++) chk_disp("full.rd", 3'(a));

    // Wrap-around and dequeue on empty
    do_reset();
    for (int i = 0; i < 8; i++) do_op("wenq", 1'b1, 1'b0, 4'(15 - i));
    for (int i = 0; i < 8; i++) do_op("wdeq", 1'b0, 1'b1, 4'd0);
    chk("wrap.lastout", out_s, 4'd8);
    do_op("deq_empty", 1'b0, 1'b1, 4'd0);
    chk("deq_empty.out", out_s, 4'd8);
    do_op("wrap7", 1'b1, 1'b0, 4'd7);
    chk("wrap7.valid", valid_s, 8'h01);
    chk("wrap7.p", p_s, 3'd0);
    chk_disp("wrap7.rd0", 3'd0);

    // Simultaneous edges on an empty queue; stall window and held read data
    do_reset();
    ra_disp_s = 3'd0;
    pulse(1'b1, 1'b1, 4'd4);
    stalls = 0; stall_at = -1;
    rd_during = 'x; rd_after = 'x; out_at4 = 'x;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 3) out_at4 = out_s;
      if (disp_stall_s === 1'b1) begin
        stalls++;
        stall_at  = i;
        rd_during = rd_disp_s;
        ra_disp_s = 3'd1;
      end else if (i > 0 && stall_at == i - 1) begin
        rd_after = rd_disp_s;
      end
    end
    chk("sim.stall_cycles", stalls, 1);
    chk("sim.stall_at", stall_at, 2);
    chk("sim.rd_during", rd_during, 4'd4);
    chk("sim.rd_held", rd_after, 4'd4);
    chk("sim.out_k4", out_at4, 4'd4);
    m_enq(4'd4);
    m_deq();
    check_all("sim");

    // Reset asserted inside the ENQ cycle
    do_reset();
    ra_disp_s = 3'd0;
    pulse(1'b1, 1'b1, 4'd6);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("abort.valid_low", valid_s, 0);
    #2 rstn = 1'b1;
    m_reset();
    repeat (6) @(posedge clk);
    #1;
    check_all("abort");
    chk("abort.rd0", rd_disp_s, 0);

    // Randomized operation mix against the model
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      do_op("rnd.enq", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
      else if (r < 8) do_op("rnd.deq", 1'b0, 1'b1, 4'd0);
      else            do_op("rnd.both", 1'b1, 1'b1, 4'($urandom_range(0, 15)));
      if (n % 4 == 0) chk_disp("rnd.rd", 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
